// File: rtl/uart_bit_tx_if.sv
// rtl/uart_bit_tx_if.sv - parallel-word handshake and serial line bundle for uart_bit_tx
interface uart_bit_tx_if #(
    parameter int packetSize = 4
);
    logic [packetSize-1:0] dIn;
    logic                  send;
    logic                  ready;
    logic                  txOut;
    logic                  done;
    logic                  HERE;

    modport master (
        output dIn,
        output send,
        input  ready,
        input  txOut,
        input  done,
        input  HERE
    );

    modport slave (
        input  dIn,
        input  send,
        output ready,
        output txOut,
        output done,
        output HERE
    );
endinterface

// File: rtl/uart_bit_tx.sv
// rtl/uart_bit_tx.sv - UART transmitter: start, LSB-first data, optional even parity, stop
// Optional parity bit compiled in with UART_TX_PARITY_EN.
module uart_bit_tx #(
    parameter int packetSize = 4,
    parameter int cycleDiv   = 100
) (
    input  logic         clk,
    input  logic         rst,
    uart_bit_tx_if.slave bus
);
    localparam int CW = $clog2(cycleDiv);
    localparam int BW = $clog2(packetSize + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(cycleDiv - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(packetSize - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [BW-1:0]         bitcnt, bitcnt_n;
    logic [packetSize-1:0] shreg, shreg_n;
    logic                  bit_end;
    logic                  tx_q, tx_n;
    logic                  ready_q, ready_n;
    logic                  done_q, done_n;
    logic                  here_q, here_n;
`ifdef UART_TX_PARITY_EN
    logic                  par, par_n;
`endif

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            here_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bitcnt  <= bitcnt_n;
            shreg   <= shreg_n;
            tx_q    <= tx_n;
            ready_q <= ready_n;
            done_q  <= done_n;
            here_q  <= here_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
`ifdef UART_TX_PARITY_EN
        par_n    = par;
`endif
        bit_end  = (cnt == CNT_LAST);
        if (state != S_IDLE) begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
        end
        case (state)
            S_IDLE: begin
                if (bus.send) begin
                    state_n = S_START;
                    cnt_n   = '0;
                    shreg_n = bus.dIn;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^bus.dIn;
`endif
                end
            end
            S_START: begin
                if (bit_end) state_n = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (bitcnt == BIT_LAST) begin
                        bitcnt_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n  = S_PARITY;
`else
                        state_n  = S_STOP;
`endif
                    end else begin
                        bitcnt_n = bitcnt + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_n = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_n = par_n;
`endif
            default:  tx_n = 1'b1;
        endcase
        ready_n = (state_n == S_IDLE);
        done_n  = (state_n == S_STOP) && (cnt_n == CNT_LAST);
        here_n  = (state_n != S_IDLE) && (cnt_n == '0);
    end

    assign bus.txOut = tx_q;
    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.HERE  = here_q;
endmodule

// File: tb/tb_uart_bit_tx.sv
// tb/tb_uart_bit_tx.sv - scoreboard bench for uart_bit_tx (packetSize=4, cycleDiv=10)
module tb_uart_bit_tx;
    localparam int P = 4;
    localparam int D = 10;
`ifdef UART_TX_PARITY_EN
    localparam int L = (P + 3) * D;
    localparam bit PAR = 1'b1;
`else
    localparam int L = (P + 2) * D;
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_bit_tx_if #(.packetSize(P)) bus ();

    uart_bit_tx #(.packetSize(P), .cycleDiv(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         done_seen = 0;
    bit         check_idle = 1'b0;
    logic [3:0] exp_q[$];

    // Each entry is {txOut, done, HERE, ready} for one clock.
    task automatic push_frame(input logic [P-1:0] w, input int upto);
        for (int c = 1; c <= L && c <= upto; c++) begin
            int   b;
            int   ph;
            logic line;
            b  = (c - 1) / D;
            ph = (c - 1) % D;
            if (b == 0)                  line = 1'b0;
            else if (b <= P)             line = w[b-1];
            else if (PAR && b == P + 1)  line = ^w;
            else                         line = 1'b1;
            exp_q.push_back({line, (c == L), (ph == 0), 1'b0});
        end
    endtask

    task automatic send_word(input logic [P-1:0] w, input int upto);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (bus.ready !== 1'b1 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        bus.dIn  = w;
        bus.send = 1'b1;
        @(posedge clk); #1;
        bus.send = 1'b0;
        bus.dIn  = ~w;
        push_frame(w, upto);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [3:0] obs;
        logic [3:0] e;
        obs = {bus.txOut, bus.done, bus.HERE, bus.ready};
        if (bus.done === 1'b1) done_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL frame_cycle t=%0t got {tx,done,here,ready}=%b expected %b", $time, obs, e);
            end
        end else if (check_idle) begin
            checks++;
            if (obs !== 4'b1001) begin
                errors++;
                $display("FAIL idle_line t=%0t got {tx,done,here,ready}=%b expected 1001", $time, obs);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.txOut, bus.ready, bus.done, bus.HERE} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_values got %b expected 1100", {bus.txOut, bus.ready, bus.done, bus.HERE});
        end
        check_idle = 1'b1;
        repeat (100) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int d0;
        d0 = done_seen;
        send_word(4'b1011, L);
        repeat (L) @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.ready !== 1'b1 || bus.txOut !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_frame got ready=%b tx=%b expected 1 1", bus.ready, bus.txOut);
        end
        checks++;
        if (done_seen - d0 !== 1) begin
            errors++;
            $display("FAIL single_done_count got %0d expected 1", done_seen - d0);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL single_drain got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_busy_ignore();
        int d0;
        d0 = done_seen;
        send_word(4'b0110, L);
        repeat (24) @(posedge clk);
        #1;
        bus.dIn  = 4'b1111;
        bus.send = 1'b1;
        @(posedge clk); #1;
        bus.send = 1'b0;
        wait_drain();
        repeat (20) @(negedge clk);
        checks++;
        if (done_seen - d0 !== 1) begin
            errors++;
            $display("FAIL busy_done_count got %0d expected 1", done_seen - d0);
        end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first  = -1;
        second = -1;
        @(posedge clk); #1;
        bus.dIn  = 4'b0001;
        bus.send = 1'b1;
        @(posedge clk); #1;
        push_frame(4'b0001, L);
        exp_q.push_back(4'b1001);
        push_frame(4'b1000, L);
        bus.dIn = 4'b1000;
        for (int cyc = 1; cyc <= 2 * L + 10; cyc++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
            if (cyc == L + 1) begin
                @(posedge clk); #1;
                bus.send = 1'b0;
            end
        end
        checks++;
        if (first !== L || second !== 2 * L + 1) begin
            errors++;
            $display("FAIL b2b_done_cycles got %0d,%0d expected %0d,%0d", first, second, L, 2 * L + 1);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_drain got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        d0 = done_seen;
        send_word(4'b0000, 23);
        repeat (22) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.txOut, bus.ready, bus.done} !== 3'b110) begin
            errors++;
            $display("FAIL midreset_idle got {tx,ready,done}=%b expected 110", {bus.txOut, bus.ready, bus.done});
        end
        repeat (L) @(negedge clk);
        checks++;
        if (done_seen !== d0) begin
            errors++;
            $display("FAIL midreset_no_done got %0d pulses expected 0", done_seen - d0);
        end
        send_word(4'b1010, L);
        wait_drain();
    endtask

    task automatic test_random_words();
        for (int i = 0; i < 4; i++) begin
            logic [P-1:0] w;
            w = P'($urandom_range(0, (1 << P) - 1));
            send_word(w, L);
            wait_drain();
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        send_word(4'b0111, L);
        wait_drain();
        send_word(4'b0011, L);
        wait_drain();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout bench did not complete");
        $fatal(1);
    end

    initial begin
        bus.dIn  = '0;
        bus.send = 1'b0;
        test_reset();
        test_single_frame();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_words();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL final_drain got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
